// File: rtl/rv_pkg.sv
// Shared definitions for the ready/valid burst source: FSM state encoding and
// the default payload width.
package rv_pkg;

    localparam int RV_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } rv_state_e;

endpackage : rv_pkg

// File: rtl/rv_stream_source.sv
// Burst stream source. On an accepted start it emits len beats of an
// incrementing payload (starting at start_data) over a valid/ready stream,
// optionally separating beats with gap idle cycles, then pulses done.
//
// Handshake: a beat transfers on any rising edge where out_valid and out_ready
// are both high. Once out_valid rises it stays high, with out_data stable,
// until that transfer happens. out_ready while out_valid is low is ignored.
//
// Every output comes straight from a flop. Each flop's next value is decoded
// from the next FSM state, so out_ready reaches outputs only through registers.
module rv_stream_source
    import rv_pkg::*;
#(
    parameter int DATA_W = RV_DATA_W,
    parameter int LEN_W  = 16,
    parameter int GAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic [LEN_W-1:0]  len,
    input  logic [GAP_W-1:0]  gap,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  beat_cnt
);

    rv_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic [LEN_W-1:0]  cnt_inc;

    assign accept  = valid_q && out_ready;
    assign cnt_inc = cnt_q + LEN_W'(1);

    // Next-state logic: FSM transitions, burst counters and registered outputs.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = len;
                    gap_d  = gap;
                    data_d = start_data;
                    cnt_d  = '0;
                    // A zero-length burst completes without issuing a beat.
                    state_d = (len != '0) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (accept) begin
                    cnt_d  = cnt_inc;
                    data_d = data_q + DATA_W'(1);
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end else if (gap_q == '0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end
                end
            end
            ST_GAP: begin
                // gap_cnt holds the idle cycles left including this one.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                // start is deliberately not sampled here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_SEND);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign beat_cnt  = cnt_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule : rv_stream_source
